// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Optional accumulator feature is controlled by macro ALU_ACC_EN (see the top and interface).
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

  typedef struct packed {
    logic [7:0] g;
    logic       ovf;
    logic [7:0] rem;
    logic       dbz;
  } rsp_t;

  function automatic logic is_div_by_zero(input logic [1:0] op, input logic [7:0] b);
    return (op_e'(op) == OP_DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response bundle of the ALU operation sequencer.
// Macro ALU_ACC_EN adds the req_use_acc request bit.
interface alu_op_sequencer_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_cin;
`ifdef ALU_ACC_EN
  logic       req_use_acc;
`endif

  logic [7:0] alu_A;
  logic [7:0] alu_B;
  logic       alu_S1;
  logic       alu_S0;
  logic       alu_Cin;
  logic [7:0] alu_G;
  logic       alu_Overflow;
  logic [7:0] alu_Du;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_g;
  logic       rsp_ovf;
  logic [7:0] rsp_rem;
  logic       rsp_dbz;

  // slave = the sequencer; master = front-end plus the ALU it drives
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin,
`ifdef ALU_ACC_EN
    input  req_use_acc,
`endif
    output req_ready,
    output alu_A, alu_B, alu_S1, alu_S0, alu_Cin,
    input  alu_G, alu_Overflow, alu_Du,
    output rsp_valid, rsp_g, rsp_ovf, rsp_rem, rsp_dbz,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin,
`ifdef ALU_ACC_EN
    output req_use_acc,
`endif
    input  req_ready,
    input  alu_A, alu_B, alu_S1, alu_S0, alu_Cin,
    output alu_G, alu_Overflow, alu_Du,
    input  rsp_valid, rsp_g, rsp_ovf, rsp_rem, rsp_dbz,
    output rsp_ready
  );

endinterface

// File: rtl/alu_rsp_reg.sv
// Capture/hold register for the response fields with the rsp_valid/rsp_ready handshake.
// Fields stay stable until the next capture; handshake flags the accepting edge.
module alu_rsp_reg
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  rsp_t cap_data,
  input  logic rsp_ready,
  output logic rsp_valid,
  output rsp_t rsp,
  output logic handshake
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp       <= cap_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign handshake = rsp_valid & rsp_ready;

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational 8-bit ALU: one operation in flight, settle wait, response capture.
// Macro ALU_ACC_EN adds an accumulator that can replace operand A.
//
// state     | meaning
// ST_IDLE   | req_ready high, alu_* hold last operation
// ST_SETTLE | alu_* stable, settle counter running down to capture
// ST_RESP   | rsp_valid high, waiting for rsp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [CNT_W-1:0]    op_count
);

  // Edges spent in ST_SETTLE before the capture edge
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  state_e     state;
  logic [3:0] settle_cnt;
  logic       dbz_pend;
  logic [7:0] a_eff;
  logic       capture;
  logic       handshake;
  logic       rsp_valid;
  rsp_t       cap_data;
  rsp_t       rsp;

`ifdef ALU_ACC_EN
  logic [7:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 8'h00;
    end else if (handshake && !rsp.dbz) begin
      acc <= rsp.g;
    end
  end

  always_comb begin
    a_eff = bus.req_use_acc ? acc : bus.req_a;
  end
`else
  always_comb begin
    a_eff = bus.req_a;
  end
`endif

  assign capture = (state == ST_SETTLE) && (settle_cnt == 4'd0);

  // Divide-by-zero reports the operand actually loaded onto alu_A as remainder
  always_comb begin
    cap_data = '0;
    if (dbz_pend) begin
      cap_data.g   = DBZ_QUOTIENT;
      cap_data.ovf = 1'b0;
      cap_data.rem = bus.alu_A;
      cap_data.dbz = 1'b1;
    end else begin
      cap_data.g   = bus.alu_G;
      cap_data.ovf = bus.alu_Overflow;
      cap_data.rem = (bus.alu_S1 && bus.alu_S0) ? bus.alu_Du : 8'h00;
      cap_data.dbz = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      settle_cnt    <= 4'd0;
      dbz_pend      <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.alu_A     <= 8'h00;
      bus.alu_B     <= 8'h00;
      bus.alu_S1    <= 1'b0;
      bus.alu_S0    <= 1'b0;
      bus.alu_Cin   <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.alu_A     <= a_eff;
            bus.alu_B     <= bus.req_b;
            bus.alu_S1    <= bus.req_op[1];
            bus.alu_S0    <= bus.req_op[0];
            bus.alu_Cin   <= bus.req_cin;
            bus.req_ready <= 1'b0;
            state         <= ST_SETTLE;
            if (is_div_by_zero(bus.req_op, bus.req_b)) begin
              settle_cnt <= 4'd0;
              dbz_pend   <= 1'b1;
            end else begin
              settle_cnt <= SETTLE_LOAD;
              dbz_pend   <= 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (handshake) begin
            state         <= ST_IDLE;
            bus.req_ready <= 1'b1;
            op_count      <= op_count + CNT_W'(1);
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

  alu_rsp_reg u_rsp_reg (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .cap_data  (cap_data),
    .rsp_ready (bus.rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp       (rsp),
    .handshake (handshake)
  );

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_g     = rsp.g;
  assign bus.rsp_ovf   = rsp.ovf;
  assign bus.rsp_rem   = rsp.rem;
  assign bus.rsp_dbz   = rsp.dbz;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: randomized and directed requests against an arithmetic reference model.
module tb_alu_op_sequencer;

  localparam int SETTLE = 2;
  localparam int CW     = 4;
`ifdef ALU_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  typedef struct {
    logic [7:0] g;
    logic       ovf;
    logic [7:0] rem;
    logic       dbz;
    int         rise;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] op_count;
  logic [CW-1:0] exp_count;
  logic [15:0]   alu_p;
  logic [7:0]    model_acc;
  logic          prev_valid;
  logic          rand_rdy;
  int            cyc;
  int            n_cmp;
  int            n_bad;
  exp_t          sb[$];

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU the sequencer drives
  always_comb begin
    bus.alu_G        = 8'h00;
    bus.alu_Overflow = 1'b0;
    bus.alu_Du       = 8'h00;
    alu_p            = 16'h0000;
    case ({bus.alu_S1, bus.alu_S0})
      2'b00: {bus.alu_Overflow, bus.alu_G} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + 9'(bus.alu_Cin);
      2'b01: {bus.alu_Overflow, bus.alu_G} = {1'b0, bus.alu_A} - {1'b0, bus.alu_B} - 9'(bus.alu_Cin);
      2'b10: begin
        alu_p            = 16'(bus.alu_A) * 16'(bus.alu_B);
        bus.alu_G        = alu_p[7:0];
        bus.alu_Overflow = |alu_p[15:8];
      end
      default: begin
        if (bus.alu_B != 8'h00) begin
          bus.alu_G  = bus.alu_A / bus.alu_B;
          bus.alu_Du = bus.alu_A % bus.alu_B;
        end
      end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_count  = '0;
      prev_valid = 1'b0;
    end else begin
      chk("op_count", 32'(op_count), 32'(exp_count));
      if (bus.rsp_valid) begin
        chk("req_ready_during_rsp", 32'(bus.req_ready), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) chk("latency_cycle", 32'(cyc), 32'(sb[0].rise));
          chk("rsp_g",   32'(bus.rsp_g),   32'(sb[0].g));
          chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(sb[0].ovf));
          chk("rsp_rem", 32'(bus.rsp_rem), 32'(sb[0].rem));
          chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(sb[0].dbz));
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            exp_count = exp_count + CW'(1);
          end
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  initial begin
    rand_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic use_acc);
    int   n;
    int   av;
    int   d;
    exp_t e;
    @(posedge clk); #2;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
`ifdef ALU_ACC_EN
    bus.req_use_acc = use_acc;
`endif
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    av    = (ACC && use_acc) ? int'(model_acc) : int'(a);
    e.rem = 8'h00;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    case (op)
      2'b00: begin d = av + int'(b) + int'(cin); e.g = 8'(d); e.ovf = (d > 255); end
      2'b01: begin d = av - int'(b) - int'(cin); e.g = 8'(d); e.ovf = (d < 0); end
      2'b10: begin d = av * int'(b); e.g = 8'(d); e.ovf = (d > 255); end
      default: begin
        if (b == 8'h00) begin
          e.g = 8'hFF; e.rem = 8'(av); e.dbz = 1'b1;
        end else begin
          e.g = 8'(av / int'(b)); e.rem = 8'(av % int'(b));
        end
      end
    endcase
    e.rise = cyc + 1 + (e.dbz ? 1 : SETTLE + 1);
    if (ACC && !e.dbz) model_acc = e.g;
    sb.push_back(e);
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rand_rdy      = 1'b0;
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #2;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_fields", {13'd0, bus.rsp_g, bus.rsp_ovf, bus.rsp_rem, bus.rsp_dbz}, 32'd0);
    chk("rst_alu_lines", {11'd0, bus.alu_A, bus.alu_B, bus.alu_S1, bus.alu_S0, bus.alu_Cin}, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst       = 1'b1;
    model_acc = 8'h00;
    check_reset_outputs();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    model_acc     = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.req_cin   = 1'b0;
`ifdef ALU_ACC_EN
    bus.req_use_acc = 1'b0;
`endif
    bus.rsp_ready = 1'b1;
    check_reset_outputs();
    @(posedge clk); #2;
    rst = 1'b0;

    send(2'b00, 8'hF0, 8'h20, 1'b0, 1'b0);
    send(2'b11, 8'h17, 8'h05, 1'b0, 1'b0);
    send(2'b11, 8'h17, 8'h00, 1'b0, 1'b0);
    drain();

    // Response stall with a competing request
    bus.rsp_ready = 1'b0;
    send(2'b01, 8'h05, 8'h07, 1'b0, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("stall_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    bus.req_op    = 2'b00;
    bus.req_a     = 8'h11;
    bus.req_b     = 8'h22;
    bus.req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset in the middle of a MUL settle
    send(2'b10, 8'h10, 8'h10, 1'b0, 1'b0);
    do_reset();
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    for (int i = 0; i < 3; i++) send(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    drain();
    chk("count_three", 32'(op_count), 32'd3);
    for (int i = 0; i < (1 << CW) - 3; i++) send(2'b00, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    drain();
    chk("count_wrap", 32'(op_count), 32'd0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      send(2'($urandom), 8'($urandom), rb, 1'($urandom), 1'($urandom));
    end
    drain();

`ifdef ALU_ACC_EN
    do_reset();
    send(2'b00, 8'h05, 8'h03, 1'b0, 1'b0);
    send(2'b00, 8'($urandom), 8'h02, 1'b0, 1'b1);
    drain();
    do_reset();
    send(2'b00, 8'h77, 8'h01, 1'b0, 1'b1);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below %0d", cyc, 30000);
    $fatal(1);
  end

endmodule
